// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair.
package spi_pkg;

  localparam int unsigned SPI_N = 11;

  // Bit counter width; the count saturates at its maximum.
  localparam int unsigned CNT_W = 4;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic LOAD_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_state_e;

  // Saturating increment of the bit counter.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Single-bit synchroniser with one delay flop for edge detection.
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  // Synchroniser chain plus edge-detect delay flop, reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign q    = r_sync[STAGES-1];
  assign rise = q & ~r_dly;
  assign fall = ~q & r_dly;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples SCLK/LOAD/MOSI on the system clock, captures an
// N-bit word per frame and shifts a reply word out on MISO.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned N           = SPI_N,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         SCLK,
  input  logic         LOAD,
  input  logic         MOSI,
  input  logic [N-1:0] S_TX_DAT,
  output logic         MISO,
  output logic [N-1:0] S_RX_DAT,
  output logic         rx_vld,
  output logic         rx_err,
  output logic         busy
);

  localparam logic [CNT_W-1:0] CntN = CNT_W'(N);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_load_q, w_load_rise, w_load_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SCLK),
    .q    (w_sclk_q),
    .rise (w_sclk_rise),
    .fall (w_sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(LOAD_IDLE)) u_sync_load (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (LOAD),
    .q    (w_load_q),
    .rise (w_load_rise),
    .fall (w_load_fall)
  );

  // Same depth as SCLK so the sampled data bit lines up with the clock edge.
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (MOSI),
    .q    (w_mosi_q),
    .rise (w_mosi_rise),
    .fall (w_mosi_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_sclk_q, w_mosi_rise, w_mosi_fall};

  spi_state_e       r_state, w_state_nxt;
  logic [N-1:0]     r_rx_sh, w_rx_sh_nxt;
  logic [N-1:0]     r_tx_sh, w_tx_sh_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0]     r_rx_dat, w_rx_dat_nxt;
  logic             r_vld, w_vld_nxt;
  logic             r_err, w_err_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_miso, w_miso_nxt;
  logic             r_pend, w_pend_nxt;

  // After reset the synchronisers still hold idle levels. A slave reset in mid-frame
  // would otherwise see a false LOAD fall once they flush, so frames are only accepted
  // after the flush completes and LOAD has been seen idle.
  logic [SYNC_STAGES:0] r_flush;
  logic                 r_armed;
  logic                 w_start;

  // Post-reset flush tracker and arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush <= '0;
      r_armed <= 1'b0;
    end else begin
      r_flush <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      r_armed <= r_armed | (r_flush[SYNC_STAGES] & w_load_q);
    end
  end

  // A LOAD fall seen during DONE is held in r_pend and honoured in IDLE.
  assign w_start = r_armed & (w_load_fall | r_pend);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_state_nxt = SHIFT;
      SHIFT:   if (w_load_rise) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values; a bit arriving with the LOAD rise is still counted.
  always_comb begin
    w_rx_sh_nxt  = r_rx_sh;
    w_tx_sh_nxt  = r_tx_sh;
    w_cnt_nxt    = r_cnt;
    w_rx_dat_nxt = r_rx_dat;
    w_vld_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_busy_nxt   = r_busy;
    w_pend_nxt   = r_pend;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_tx_sh_nxt = S_TX_DAT;
          w_rx_sh_nxt = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_pend_nxt  = 1'b0;
        end
      end
      SHIFT: begin
        if (w_sclk_rise) begin
          w_rx_sh_nxt = {r_rx_sh[N-2:0], w_mosi_q};
          w_cnt_nxt   = cnt_sat_inc(r_cnt);
        end
        if (w_sclk_fall) begin
          w_tx_sh_nxt = {r_tx_sh[N-2:0], 1'b0};
        end
      end
      DONE: begin
        if (r_cnt == CntN) begin
          w_rx_dat_nxt = r_rx_sh;
          w_vld_nxt    = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
        w_busy_nxt = 1'b0;
        if (w_load_fall) w_pend_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
    w_miso_nxt = w_busy_nxt & w_tx_sh_nxt[N-1];
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sh  <= '0;
      r_tx_sh  <= '0;
      r_cnt    <= '0;
      r_rx_dat <= '0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_miso   <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_rx_sh  <= w_rx_sh_nxt;
      r_tx_sh  <= w_tx_sh_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rx_dat <= w_rx_dat_nxt;
      r_vld    <= w_vld_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= w_busy_nxt;
      r_miso   <= w_miso_nxt;
      r_pend   <= w_pend_nxt;
    end
  end

  assign MISO     = r_miso;
  assign S_RX_DAT = r_rx_dat;
  assign rx_vld   = r_vld;
  assign rx_err   = r_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI frames at SCLK = clk/4.
module tb_spi_slave_rx;

  localparam int unsigned N = 11;

  logic         clk;
  logic         rst_n;
  logic         SCLK;
  logic         LOAD;
  logic         MOSI;
  logic [N-1:0] S_TX_DAT;
  logic         MISO;
  logic [N-1:0] S_RX_DAT;
  logic         rx_vld;
  logic         rx_err;
  logic         busy;

  spi_slave_rx #(.N(N), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SCLK    (SCLK),
    .LOAD    (LOAD),
    .MOSI    (MOSI),
    .S_TX_DAT(S_TX_DAT),
    .MISO    (MISO),
    .S_RX_DAT(S_RX_DAT),
    .rx_vld  (rx_vld),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int           vld_cnt = 0;
  int           err_cnt = 0;
  logic [N-1:0] vld_log[$];

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_vld === 1'b1) begin
      vld_cnt++;
      vld_log.push_back(S_RX_DAT);
    end
    if (rx_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: raise LOAD a half-period after the last fall; mode 1: raise LOAD together
  // with the last SCLK rise; mode 2: leave LOAD low (frame left open).
  task automatic frame(input logic [15:0] data, input int nbits, input int mode,
                       output logic [N-1:0] miso_bits);
    miso_bits = '0;
    LOAD = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = data[nbits-1-i];
      repeat (2) @(negedge clk);
      SCLK = 1'b1;
      if (mode == 1 && i == nbits - 1) LOAD = 1'b1;
      repeat (2) @(negedge clk);
      if (i < N) miso_bits[N-1-i] = MISO;
      SCLK = 1'b0;
    end
    if (mode == 0) begin
      repeat (2) @(negedge clk);
      LOAD = 1'b1;
    end
  endtask

  // Called right after LOAD rises: the result pulse lands on the 4th clk edge.
  task automatic finish_check(input string tag, input logic exp_vld,
                              input logic [N-1:0] exp_dat);
    repeat (3) @(negedge clk);
    check({tag, ".vld_early"}, 16'(rx_vld), 16'h0);
    check({tag, ".busy_held"}, 16'(busy), 16'h1);
    @(negedge clk);
    check({tag, ".vld"}, 16'(rx_vld), 16'(exp_vld));
    check({tag, ".err"}, 16'(rx_err), 16'(!exp_vld));
    check({tag, ".busy_low"}, 16'(busy), 16'h0);
    check({tag, ".dat"}, 16'(S_RX_DAT), 16'(exp_dat));
    @(negedge clk);
    check({tag, ".pulse_end"}, 16'(rx_vld | rx_err), 16'h0);
  endtask

  initial begin
    logic [N-1:0] bits;
    int           base_vld;
    int           base_err;
    logic         miso_or;

    rst_n    = 1'b0;
    SCLK     = 1'b0;
    LOAD     = 1'b1;
    MOSI     = 1'b0;
    S_TX_DAT = '0;
    repeat (3) @(negedge clk);
    check("rst.dat", 16'(S_RX_DAT), 16'h0);
    check("rst.miso", 16'(MISO), 16'h0);
    check("rst.vld", 16'(rx_vld), 16'h0);
    check("rst.err", 16'(rx_err), 16'h0);
    check("rst.busy", 16'(busy), 16'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Nominal frame with reply.
    S_TX_DAT = 11'h5A3;
    frame(16'h2CC, 11, 0, bits);
    check("f1.miso_bits", 16'(bits), 16'h05A3);
    finish_check("f1", 1'b1, 11'h2CC);
    check("f1.vld_count", 16'(vld_cnt), 16'd1);

    // Short frame.
    S_TX_DAT = 11'h000;
    frame(16'h0155, 10, 0, bits);
    finish_check("short10", 1'b0, 11'h2CC);

    // Long frame, then a good one.
    frame(16'h0ABC, 12, 0, bits);
    finish_check("long12", 1'b0, 11'h2CC);
    frame(16'h07FF, 11, 0, bits);
    finish_check("f7ff", 1'b1, 11'h7FF);
    check("err_count", 16'(err_cnt), 16'd2);

    // Reset in mid-frame after 5 bits.
    base_vld = vld_cnt;
    base_err = err_cnt;
    frame(16'h001F, 5, 2, bits);
    check("midrst.busy_before", 16'(busy), 16'h1);
    rst_n = 1'b0;
    #1;
    check("midrst.dat", 16'(S_RX_DAT), 16'h0);
    check("midrst.busy", 16'(busy), 16'h0);
    check("midrst.miso", 16'(MISO), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    LOAD = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst.no_vld", 16'(vld_cnt - base_vld), 16'h0);
    check("midrst.no_err", 16'(err_cnt - base_err), 16'h0);
    check("midrst.busy_after", 16'(busy), 16'h0);
    check("midrst.dat_after", 16'(S_RX_DAT), 16'h0);
    frame(16'h0001, 11, 0, bits);
    finish_check("f001", 1'b1, 11'h001);

    // SCLK activity while LOAD idles high.
    base_vld = vld_cnt;
    base_err = err_cnt;
    miso_or  = 1'b0;
    MOSI     = 1'b1;
    for (int i = 0; i < 11; i++) begin
      SCLK = 1'b1;
      repeat (2) @(negedge clk);
      miso_or = miso_or | MISO | busy;
      SCLK = 1'b0;
      repeat (2) @(negedge clk);
      miso_or = miso_or | MISO | busy;
    end
    repeat (4) @(negedge clk);
    check("idle_sclk.miso_busy", 16'(miso_or), 16'h0);
    check("idle_sclk.dat", 16'(S_RX_DAT), 16'h001);
    check("idle_sclk.no_vld", 16'(vld_cnt - base_vld), 16'h0);
    check("idle_sclk.no_err", 16'(err_cnt - base_err), 16'h0);

    // Back-to-back frames, LOAD high for one half-period, last rise aligned with LOAD rise.
    base_vld = vld_cnt;
    base_err = err_cnt;
    frame(16'h0155, 11, 1, bits);
    frame(16'h02AA, 11, 1, bits);
    repeat (10) @(negedge clk);
    check("b2b.vld_count", 16'(vld_cnt - base_vld), 16'd2);
    check("b2b.no_err", 16'(err_cnt - base_err), 16'h0);
    if (vld_log.size() >= base_vld + 2) begin
      check("b2b.word0", 16'(vld_log[base_vld]), 16'h0155);
      check("b2b.word1", 16'(vld_log[base_vld+1]), 16'h02AA);
    end else begin
      check("b2b.log_size", 16'(vld_log.size()), 16'(base_vld + 2));
    end
    check("b2b.dat", 16'(S_RX_DAT), 16'h02AA);
    check("b2b.busy", 16'(busy), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI slave endpoint that receives the 11-bit frames sent by the team's SPI master on SCLK/MOSI/LOAD.
- Runs on the system clock and oversamples the master's signals; it does not use SCLK as a clock.
- Presents each received word with a one-cycle valid strobe and a frame-error flag.
- Shifts a local reply word back on MISO during the same frame.

Parameters:
- N, 11, frame length in bits (matches the master's M_TX_DAT width).
- SYNC_STAGES, 2, synchroniser depth for SCLK/LOAD/MOSI; legal values 2..3.

Ports:
- clk  in  1  system clock; must run at ≥4× the SCLK frequency.
- rst_n  in  1  asynchronous active-low reset.
- SCLK  in  1  serial clock from the master; idles low.
- LOAD  in  1  frame strobe; high when idle, low during a frame, rising edge ends the frame.
- MOSI  in  1  serial data from the master, MSB first, stable around the rising edge of SCLK.
- S_TX_DAT  in  N  reply word, captured at frame start.
- MISO  out  1  serial reply, MSB first, changes after the falling edge of SCLK.
- S_RX_DAT  out  N  last correctly received word.
- rx_vld  out  1  one-cycle pulse when S_RX_DAT is updated.
- rx_err  out  1  one-cycle pulse when a frame ends with bit count ≠ N.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: S_RX_DAT=0, MISO=0, rx_vld=0, rx_err=0, busy=0; synchroniser flops reset to the idle levels (SCLK=0, LOAD=1, MOSI=0); state=IDLE; bit count=0.
- Synchronisers: SCLK, LOAD and MOSI each pass through SYNC_STAGES flops, then one delay flop for edge detection.
  - Edge pulses: sclk_rise, sclk_fall, load_fall, load_rise.
  - MOSI uses the same depth as SCLK so that data and clock stay aligned.
- State machine:
  - IDLE: on load_fall, capture S_TX_DAT into the tx shift register, set bit count to 0, set busy=1, go to SHIFT.
  - SHIFT:
    - On sclk_rise: shift synced MOSI into the LSB of the rx shift register and increment the bit count (saturates at 15).
    - On sclk_fall: shift the tx register left and fill the LSB with 0.
    - On load_rise: go to DONE.
  - DONE (one cycle): if count==N, load S_RX_DAT from the rx shift register and pulse rx_vld; otherwise pulse rx_err and leave S_RX_DAT unchanged. Then busy=0 and go to IDLE.
- MISO = tx register MSB while busy=1, otherwise 0. MISO is registered (no tristate).
- Latency:
  - rx_vld is high for exactly one cycle, SYNC_STAGES+2 clk cycles after the first clk edge that samples LOAD high.
  - With the default, that is 4 cycles.
- Simultaneous sclk_rise and load_rise in the same cycle: the bit is shifted and counted first, then the state moves to DONE.
- More than N rising edges: the rx register keeps the last N bits; count>N gives rx_err.
- Fewer than N rising edges, including a zero-bit frame: rx_err.
- SCLK edges while IDLE: ignored, and MISO stays 0.
- load_rise while IDLE (for example after a reset in mid-frame): ignored, with no rx_vld and no rx_err.
- Reset asserted mid-frame: all state returns immediately to the reset values; the partial frame is discarded.
- Back-to-back frames: a load_fall during the DONE cycle is held and starts the next frame on the following cycle. At least one idle cycle is never required.

Decomposition:
- Shared package spi_pkg:
  - SPI_N = 11.
  - State enum {IDLE, SHIFT, DONE}.
  - Idle levels SCLK_IDLE=0 and LOAD_IDLE=1.
  - Also used by the master.
- One sub-module spi_sync: a parameterised single-bit synchroniser with edge detect.
  - Inputs: clk, rst_n, d, and parameter RST_VAL.
  - Outputs: q, rise, fall.
  - Instantiated three times.

Test Plan:
- Master sends 11'h2CC (SCLK at clk/4) with S_TX_DAT=11'h5A3 → one rx_vld pulse, S_RX_DAT=11'h2CC, MISO bit sequence 1,0,1,1,0,1,0,0,0,1,1; busy falls with rx_vld.
- Frame with 10 SCLK pulses → rx_err pulse, no rx_vld, S_RX_DAT keeps its previous value.
- Frame with 12 pulses carrying 12'hABC → rx_err, S_RX_DAT unchanged; an 11-pulse 11'h7FF frame right after gives S_RX_DAT=11'h7FF.
- rst_n pulsed low after 5 bits of a frame, then LOAD rises → no rx_vld, no rx_err, all outputs at their reset values; the next full frame with 11'h001 is received correctly.
- SCLK toggling 11 times with LOAD held high → S_RX_DAT unchanged, MISO=0, busy=0.
- Two back-to-back frames 11'h155 and 11'h2AA with LOAD high for only 1 SCLK half-period → two rx_vld pulses with the values in order; last SCLK rising edge aligned to the clk cycle of the LOAD rise still gives a correct 11-bit word.
